// File: rtl/alu_pipe_if.sv
// Handshake and data bundle between the issue logic, alu_pipe and the writeback path.
interface alu_pipe_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic             in_Mode;
  logic [2:0]       operation;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             overflow;
  logic             carry;
  logic             zero;
  logic             ovf_sticky;
  logic             clr_sticky;

  modport master (
    output in_valid, in_1, in_2, in_Mode, operation, out_ready, clr_sticky,
    input  in_ready, out_valid, Result, overflow, carry, zero, ovf_sticky
  );

  modport slave (
    input  in_valid, in_1, in_2, in_Mode, operation, out_ready, clr_sticky,
    output in_ready, out_valid, Result, overflow, carry, zero, ovf_sticky
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 registers the operand beat, S2 registers result and flags.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);
  localparam int               SHW     = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MAX_SH  = WIDTH'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SLL = 3'b010,
    OP_SRL = 3'b011,
    OP_SRA = 3'b100,
    OP_NEG = 3'b101,
    OP_CMP = 3'b110,
    OP_RSV = 3'b111
  } op_t;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_mode;
  op_t              s1_op;

  logic             adv1;
  logic             adv2;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   sh;
  logic             sh_big;
  logic             gt;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;
  logic             cy_c;
  logic             zero_c;

  assign adv2         = !bus.out_valid || bus.out_ready;
  assign adv1         = !s1_valid || adv2;
  assign bus.in_ready = adv1;

  assign sum    = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff   = {1'b0, s1_a} - {1'b0, s1_b};
  assign sh     = s1_b[SHW-1:0];
  assign sh_big = s1_b > MAX_SH;
  assign gt     = s1_mode ? ($signed(s1_a) > $signed(s1_b)) : (s1_a > s1_b);

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    cy_c  = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res_c = sum[WIDTH-1:0];
        cy_c  = sum[WIDTH];
        ovf_c = s1_mode && (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = diff[WIDTH-1:0];
        cy_c  = diff[WIDTH];
        ovf_c = s1_mode && (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SLL: res_c = sh_big ? '0 : (s1_a << sh);
      OP_SRL: res_c = sh_big ? '0 : (s1_a >> sh);
      OP_SRA: begin
        // Kept out of a ternary so the shift operand stays signed.
        if (sh_big) res_c = {WIDTH{s1_a[WIDTH-1]}};
        else        res_c = $signed(s1_a) >>> sh;
      end
      OP_NEG: begin
        res_c = '0 - s1_a;
        ovf_c = s1_mode && (s1_a == MIN_NEG);
      end
      OP_CMP: begin
        if (s1_a == s1_b) res_c = WIDTH'(1);
        else if (gt)      res_c = WIDTH'(2);
        else              res_c = WIDTH'(3);
      end
      default: res_c = '0;
    endcase
    // The reserved code reports every flag low, including zero.
    zero_c = (s1_op != OP_RSV) && (res_c == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= 1'b0;
      s1_op    <= OP_ADD;
    end else if (adv1) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a    <= bus.in_1;
        s1_b    <= bus.in_2;
        s1_mode <= bus.in_Mode;
        s1_op   <= op_t'(bus.operation);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.Result    <= '0;
      bus.overflow  <= 1'b0;
      bus.carry     <= 1'b0;
      bus.zero      <= 1'b0;
    end else if (adv2) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.Result   <= res_c;
        bus.overflow <= ovf_c;
        bus.carry    <= cy_c;
        bus.zero     <= zero_c;
      end
    end
  end

  // A transfer carrying overflow takes priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.ovf_sticky <= 1'b0;
    else if (bus.out_valid && bus.out_ready && bus.overflow)
      bus.ovf_sticky <= 1'b1;
    else if (bus.clr_sticky)
      bus.ovf_sticky <= 1'b0;
  end
endmodule
